// File: rtl/bricks_pkg.sv
// ---------------------------------------------------------------------------
// bricks_pkg
// Shared constants and types for the brick-breaker scene pixel generator:
// screen size, brick geometry, paddle height, wall thickness and the
// scene-update FSM state type.
// ---------------------------------------------------------------------------
package bricks_pkg;

    localparam int unsigned SCREEN_W       = 640;
    localparam int unsigned SCREEN_H       = 480;

    localparam int unsigned BRICK_W        = 32;
    localparam int unsigned BRICK_H        = 16;
    localparam int unsigned BRICK_COLS     = 20;
    localparam int unsigned BRICK_ROWS     = 8;
    localparam int unsigned BRICK_MAP_BITS = 160;

    localparam int unsigned PADDLE_H       = 8;
    localparam int unsigned BORDER_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ACK     = 2'd2
    } upd_state_t;

    // Limit the paddle's left edge so the whole paddle stays on screen.
    function automatic logic [9:0] clamp_paddle_x(input logic [9:0] x,
                                                  input logic [9:0] x_max);
        return (x > x_max) ? x_max : x;
    endfunction

endpackage

// File: rtl/scene_hit_test.sv
// ---------------------------------------------------------------------------
// scene_hit_test
// Purely combinational region evaluator: reports which scene objects cover
// pixel (i_x, i_y). Screen-range masking is left to the caller.
//
// Configuration macro: SCENE_BORDER_EN -- when defined, the playfield walls
// (left, right and top, BORDER_W pixels thick) are reported on o_border_hit;
// otherwise o_border_hit is tied low and no wall logic exists.
//
// Ports:
//   i_x, i_y         pixel coordinate under test
//   i_bricks         brick alive map, bit = row*20 + col
//   i_paddle_x       paddle left edge (already clamped)
//   i_ball_x/y       ball top-left corner
//   o_brick_hit      pixel lies on a live brick (mortar gap excluded)
//   o_paddle_hit     pixel lies on the paddle
//   o_ball_hit       pixel lies on the ball
//   o_border_hit     pixel lies on a wall (SCENE_BORDER_EN only)
// ---------------------------------------------------------------------------
module scene_hit_test
    import bricks_pkg::*;
#(
    parameter int unsigned BRICK_TOP = 32,
    parameter int unsigned PADDLE_Y  = 448,
    parameter int unsigned PADDLE_W  = 64,
    parameter int unsigned BALL_SIZE = 8
) (
    input  logic [9:0]                i_x,
    input  logic [8:0]                i_y,
    input  logic [BRICK_MAP_BITS-1:0] i_bricks,
    input  logic [9:0]                i_paddle_x,
    input  logic [9:0]                i_ball_x,
    input  logic [8:0]                i_ball_y,
    output logic                      o_brick_hit,
    output logic                      o_paddle_hit,
    output logic                      o_ball_hit,
    output logic                      o_border_hit
);

    localparam logic [10:0] BRICK_Y0  = 11'(BRICK_TOP);
    localparam logic [10:0] BRICK_Y1  = 11'(BRICK_TOP + BRICK_ROWS * BRICK_H);
    localparam logic [10:0] PADDLE_Y0 = 11'(PADDLE_Y);
    localparam logic [10:0] PADDLE_Y1 = 11'(PADDLE_Y + PADDLE_H);
    localparam logic [10:0] PADDLE_WW = 11'(PADDLE_W);
    localparam logic [10:0] BALL_WW   = 11'(BALL_SIZE);

    // All range compares are 11 bits so object right/bottom edges near the
    // screen limit do not wrap back to small coordinates.
    logic [10:0] w_x;
    logic [10:0] w_y;
    logic [6:0]  w_dy;
    logic [2:0]  w_row;
    logic [4:0]  w_col;
    logic [7:0]  w_idx;
    logic        w_alive;
    logic        w_gap;
    logic        w_brick_band;
    logic [10:0] w_pad_x;
    logic [10:0] w_ball_x;
    logic [10:0] w_ball_y;

    assign w_x   = {1'b0, i_x};
    assign w_y   = {2'b0, i_y};
    assign w_dy  = 7'(w_y - BRICK_Y0);
    assign w_row = w_dy[6:4];
    assign w_col = i_x[9:5];
    assign w_idx = ({5'd0, w_row} * 8'(BRICK_COLS)) + {3'd0, w_col};

    // Columns 20..31 only occur off-screen; keep the index inside the map.
    assign w_alive      = (w_idx < 8'(BRICK_MAP_BITS)) ? i_bricks[w_idx] : 1'b0;
    assign w_gap        = (i_x[4:0] == 5'd31) || (w_dy[3:0] == 4'd15);
    assign w_brick_band = (w_y >= BRICK_Y0) && (w_y < BRICK_Y1);
    assign o_brick_hit  = w_brick_band && w_alive && !w_gap;

    assign w_pad_x      = {1'b0, i_paddle_x};
    assign o_paddle_hit = (w_x >= w_pad_x) && (w_x < w_pad_x + PADDLE_WW) &&
                          (w_y >= PADDLE_Y0) && (w_y < PADDLE_Y1);

    assign w_ball_x     = {1'b0, i_ball_x};
    assign w_ball_y     = {2'b0, i_ball_y};
    assign o_ball_hit   = (w_x >= w_ball_x) && (w_x < w_ball_x + BALL_WW) &&
                          (w_y >= w_ball_y) && (w_y < w_ball_y + BALL_WW);

`ifdef SCENE_BORDER_EN
    assign o_border_hit = (w_x < 11'(BORDER_W)) ||
                          (w_x >= 11'(SCREEN_W - BORDER_W)) ||
                          (w_y < 11'(BORDER_W));
`else
    assign o_border_hit = 1'b0;
`endif

endmodule

// File: rtl/scene_pixel_gen.sv
// ---------------------------------------------------------------------------
// scene_pixel_gen
// Brick-breaker scene renderer: a two-stage pipeline that decides whether a
// streamed pixel is lit, using a shadow copy of the scene that is swapped
// only at frame boundaries through an update_req / update_ack handshake.
//
// Configuration macro: SCENE_BORDER_EN -- lights the playfield walls
// (x < 8, x >= 632, y < 8); the default build leaves them dark.
//
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   frame_start      one-cycle pulse before a frame's first active pixel
//   pix_valid        qualifies pix_x / pix_y
//   pix_x, pix_y     pixel coordinate
//   bricks           brick alive map (bit = row*20 + col)
//   paddle_x         paddle left edge
//   ball_x, ball_y   ball top-left corner
//   update_req       level request to adopt the scene inputs
//   update_ack       one-cycle pulse when the scene has been adopted
//   pix_valid_o      qualifies pix_on, two cycles after the input sample
//   pix_on           pixel lit
// ---------------------------------------------------------------------------
module scene_pixel_gen
    import bricks_pkg::*;
#(
    parameter int unsigned BRICK_TOP = 32,
    parameter int unsigned PADDLE_Y  = 448,
    parameter int unsigned PADDLE_W  = 64,
    parameter int unsigned BALL_SIZE = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      frame_start,
    input  logic                      pix_valid,
    input  logic [9:0]                pix_x,
    input  logic [8:0]                pix_y,
    input  logic [BRICK_MAP_BITS-1:0] bricks,
    input  logic [9:0]                paddle_x,
    input  logic [9:0]                ball_x,
    input  logic [8:0]                ball_y,
    input  logic                      update_req,
    output logic                      update_ack,
    output logic                      pix_valid_o,
    output logic                      pix_on
);

    localparam logic [9:0] PADDLE_X_MAX = 10'(SCREEN_W - PADDLE_W);

    upd_state_t r_state;
    upd_state_t w_state_next;
    logic       w_capture;

    logic [BRICK_MAP_BITS-1:0] r_bricks;
    logic [9:0]                r_paddle_x;
    logic [9:0]                r_ball_x;
    logic [8:0]                r_ball_y;

    logic       r_s1_valid;
    logic [9:0] r_s1_x;
    logic [8:0] r_s1_y;
    logic [3:0] r_s1_hits;
    logic [3:0] w_hits;

    // ---------------- scene update FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A request that meets frame_start in the same cycle skips PENDING.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (update_req) begin
                    if (frame_start) begin
                        w_state_next = ST_ACK;
                        w_capture    = 1'b1;
                    end else begin
                        w_state_next = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (frame_start) begin
                    w_state_next = ST_ACK;
                    w_capture    = 1'b1;
                end
            end
            ST_ACK:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign update_ack = (r_state == ST_ACK);

    // ---------------- shadow scene ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bricks   <= '0;
            r_paddle_x <= '0;
            r_ball_x   <= '0;
            r_ball_y   <= '0;
        end else if (w_capture) begin
            r_bricks   <= bricks;
            r_paddle_x <= clamp_paddle_x(paddle_x, PADDLE_X_MAX);
            r_ball_x   <= ball_x;
            r_ball_y   <= ball_y;
        end
    end

    // ---------------- stage 1: region hits ----------------
    scene_hit_test #(
        .BRICK_TOP (BRICK_TOP),
        .PADDLE_Y  (PADDLE_Y),
        .PADDLE_W  (PADDLE_W),
        .BALL_SIZE (BALL_SIZE)
    ) u_hit (
        .i_x          (pix_x),
        .i_y          (pix_y),
        .i_bricks     (r_bricks),
        .i_paddle_x   (r_paddle_x),
        .i_ball_x     (r_ball_x),
        .i_ball_y     (r_ball_y),
        .o_brick_hit  (w_hits[0]),
        .o_paddle_hit (w_hits[1]),
        .o_ball_hit   (w_hits[2]),
        .o_border_hit (w_hits[3])
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_hits  <= '0;
        end else begin
            r_s1_valid <= pix_valid;
            r_s1_x     <= pix_x;
            r_s1_y     <= pix_y;
            r_s1_hits  <= w_hits;
        end
    end

    // ---------------- stage 2: combine and mask off-screen ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_valid_o <= 1'b0;
            pix_on      <= 1'b0;
        end else begin
            pix_valid_o <= r_s1_valid;
            pix_on      <= r_s1_valid && (|r_s1_hits) &&
                           (r_s1_x < 10'(SCREEN_W)) && (r_s1_y < 9'(SCREEN_H));
        end
    end

endmodule

// File: tb/tb_scene_pixel_gen.sv
module tb_scene_pixel_gen;

    localparam int BT = 32;
    localparam int PY = 448;
    localparam int PW = 64;
    localparam int BS = 8;
`ifdef SCENE_BORDER_EN
    localparam bit BORDER_ON = 1'b1;
`else
    localparam bit BORDER_ON = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         frame_start;
    logic         pix_valid;
    logic [9:0]   pix_x;
    logic [8:0]   pix_y;
    logic [159:0] bricks;
    logic [9:0]   paddle_x;
    logic [9:0]   ball_x;
    logic [8:0]   ball_y;
    logic         update_req;
    logic         update_ack;
    logic         pix_valid_o;
    logic         pix_on;

    scene_pixel_gen #(
        .BRICK_TOP (BT),
        .PADDLE_Y  (PY),
        .PADDLE_W  (PW),
        .BALL_SIZE (BS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .bricks      (bricks),
        .paddle_x    (paddle_x),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .update_req  (update_req),
        .update_ack  (update_ack),
        .pix_valid_o (pix_valid_o),
        .pix_on      (pix_on)
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int x;
        int y;
        bit exp;
        int due;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // Reference scene (what the DUT should have adopted)
    logic [159:0] m_bricks;
    int m_pad, m_bx, m_by;

    function automatic bit ref_pix(int x, int y);
        bit lit;
        int r, c;
        if (x >= 640 || y >= 480) return 1'b0;
        lit = 1'b0;
        if (y >= BT && y < BT + 128) begin
            r = (y - BT) / 16;
            c = x / 32;
            if (m_bricks[r * 20 + c] && (x % 32) != 31 && ((y - BT) % 16) != 15)
                lit = 1'b1;
        end
        if (x >= m_pad && x < m_pad + PW && y >= PY && y < PY + 8) lit = 1'b1;
        if (x >= m_bx && x < m_bx + BS && y >= m_by && y < m_by + BS) lit = 1'b1;
        if (BORDER_ON && (x < 8 || x >= 632 || y < 8)) lit = 1'b1;
        return lit;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_pix(input int x, input int y, input bit exp);
        exp_t e;
        tick();
        frame_start = 1'b0;
        pix_valid   = 1'b1;
        pix_x       = 10'(x);
        pix_y       = 9'(y);
        e.x = x; e.y = y; e.exp = exp; e.due = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            pix_valid   = 1'b0;
            frame_start = 1'b0;
        end
    endtask

    task automatic model_adopt(input logic [159:0] b, input int px, input int bx, input int by);
        m_bricks = b;
        m_pad    = (px > 576) ? 576 : px;
        m_bx     = bx;
        m_by     = by;
    endtask

    // Put new scene inputs up, run the handshake, then scramble the inputs
    // so later pixels can only be right if the adopted copy is used.
    task automatic do_update(input logic [159:0] b, input int px, input int bx,
                             input int by, input bit same_cycle);
        tick();
        pix_valid  = 1'b0;
        bricks     = b;
        paddle_x   = 10'(px);
        ball_x     = 10'(bx);
        ball_y     = 9'(by);
        update_req = 1'b1;
        frame_start = same_cycle;
        if (!same_cycle) begin
            tick();
            check("ack_before_frame", int'(update_ack), 0);
            frame_start = 1'b1;
        end
        tick();
        check("ack_pulse", int'(update_ack), 1);
        frame_start = 1'b0;
        update_req  = 1'b0;
        model_adopt(b, px, bx, by);
        tick();
        check("ack_single_cycle", int'(update_ack), 0);
        bricks   = ~b;
        paddle_x = 10'($urandom_range(0, 1023));
        ball_x   = 10'($urandom_range(0, 1023));
        ball_y   = 9'($urandom_range(0, 511));
    endtask

    task automatic rand_pixels(input int n);
        int x, y;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            tick();
            frame_start = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                pix_valid = 1'b0;
            end else begin
                case ($urandom_range(0, 7))
                    0: begin x = $urandom_range(640, 1023); y = $urandom_range(0, 511); end
                    1: begin x = $urandom_range(0, 639);    y = $urandom_range(480, 511); end
                    2: begin x = $urandom_range(0, 639);    y = $urandom_range(440, 463); end
                    3: begin x = $urandom_range(0, 639);    y = $urandom_range(BT, BT + 130); end
                    4: begin
                        x = (m_bx + $urandom_range(0, 11) + 1022) % 1024;
                        y = (m_by + $urandom_range(0, 11) + 510) % 512;
                    end
                    default: begin x = $urandom_range(0, 639); y = $urandom_range(0, 479); end
                endcase
                pix_valid = 1'b1;
                pix_x     = 10'(x);
                pix_y     = 9'(y);
                e.x = x; e.y = y; e.exp = ref_pix(x, y); e.due = cyc + 2;
                sb.push_back(e);
            end
        end
    endtask

    // Monitor: pops one expectation per valid output
    always @(negedge clock) begin
        if (!reset) begin
            if (pix_valid_o) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_miss++;
                    $display("FAIL pix_unexpected: pix_valid_o=1 at cycle %0d, expected no output", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (pix_on !== mon_e.exp || cyc != mon_e.due) begin
                        n_miss++;
                        $display("FAIL pix(%0d,%0d): pix_on=%b at cycle %0d, expected %b at cycle %0d",
                                 mon_e.x, mon_e.y, pix_on, cyc, mon_e.exp, mon_e.due);
                    end
                end
            end else begin
                n_vec++;
                if (pix_on !== 1'b0) begin
                    n_miss++;
                    $display("FAIL pix_on_idle: pix_on=%b while pix_valid_o=0, expected 0", pix_on);
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_x       = '0;
        pix_y       = '0;
        bricks      = '0;
        paddle_x    = '0;
        ball_x      = '0;
        ball_y      = '0;
        update_req  = 1'b0;
        model_adopt('0, 0, 0, 0);

        repeat (3) @(posedge clock);
        #2;
        check("rst_pix_valid_o", int'(pix_valid_o), 0);
        check("rst_pix_on", int'(pix_on), 0);
        check("rst_update_ack", int'(update_ack), 0);
        tick();
        reset = 1'b0;

        // Empty scene after reset: ball at (0,0), paddle at x=0
        send_pix(0, 0, 1'b1);
        send_pix(8, 8, 1'b0);
        send_pix(10, 450, 1'b1);
        send_pix(320, 100, 1'b0);

        // Full brick field, mortar gaps
        do_update('1, 200, 300, 300, 1'b0);
        send_pix(0, 32, 1'b1);
        send_pix(31, 32, 1'b0);
        send_pix(40, 47, 1'b0);
        send_pix(40, 32, 1'b1);
        send_pix(40, 31, 1'b0);
        send_pix(638, 158, 1'b1);
        send_pix(40, 160, 1'b0);

        // Paddle clamp
        do_update('0, 600, 300, 300, 1'b0);
        send_pix(576, 448, 1'b1);
        send_pix(600, 448, 1'b1);
        send_pix(575, 448, 1'b0);
        send_pix(600, 455, 1'b1);
        send_pix(600, 456, 1'b0);

        // update_req and frame_start together
        do_update('0, 0, 100, 200, 1'b1);
        send_pix(100, 200, 1'b1);
        send_pix(107, 207, 1'b1);
        send_pix(108, 200, 1'b0);
        send_pix(99, 200, 1'b0);

        // Ball clipped at the bottom-right corner
        do_update('0, 0, 636, 476, 1'b0);
        send_pix(639, 479, 1'b1);
        send_pix(636, 476, 1'b1);
        send_pix(0, 0, BORDER_ON);
        send_pix(700, 479, 1'b0);
        send_pix(639, 480, 1'b0);

        // Randomised scenes and pixel streams
        for (int k = 0; k < 8; k++) begin
            do_update({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()},
                      $urandom_range(0, 1023), $urandom_range(0, 1023),
                      $urandom_range(0, 511), k[0]);
            rand_pixels(80);
        end

        // Reset while PENDING with pixels in flight
        tick();
        pix_valid  = 1'b0;
        bricks     = '1;
        paddle_x   = 10'd300;
        ball_x     = 10'd400;
        ball_y     = 9'd300;
        update_req = 1'b1;
        send_pix(400, 300, 1'b0);
        send_pix(10, 40, 1'b0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_pix_valid_o", int'(pix_valid_o), 0);
        check("midrst_update_ack", int'(update_ack), 0);
        sb.delete();
        model_adopt('0, 0, 0, 0);
        tick();
        tick();
        reset      = 1'b0;
        update_req = 1'b0;
        pix_valid  = 1'b0;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("no_ack_after_reset_1", int'(update_ack), 0);
        tick();
        check("no_ack_after_reset_2", int'(update_ack), 0);
        send_pix(400, 300, 1'b0);
        send_pix(0, 0, 1'b1);
        send_pix(40, 40, 1'b0);

        // Walls on an empty scene
        send_pix(3, 200, BORDER_ON);
        send_pix(320, 200, 1'b0);
        send_pix(635, 200, BORDER_ON);
        send_pix(320, 3, BORDER_ON);
        rand_pixels(60);

        idle(5);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
